// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, response error codes,
// FSM states and the funct3 legality helper.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Stores only have byte/half/word; loads add the unsigned byte/half variants.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = ~is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response channel and data-memory channel of the load/store unit.
interface lsu_req_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  valid;
    logic                  ready;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resp_valid;
    logic [1:0]            resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output valid, is_store, funct3, addr, wdata,
        input  ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  valid, is_store, funct3, addr, wdata,
        output ready, resp_valid, resp_err, resp_rdata
    );
endinterface

interface lsu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req;
    logic                  wr_en;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready;

    modport master (
        output req, wr_en, funct3, addr, wr_data,
        input  rd_data, ready
    );

    modport slave (
        input  req, wr_en, funct3, addr, wr_data,
        output rd_data, ready
    );
endinterface

// File: rtl/load_store_unit_access_check.sv
// Combinational legality/alignment check of an incoming request.
module lsu_access_check
    import load_store_unit_pkg::*;
(
    input  logic       is_store_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output lsu_err_e   err_o
);

    // Illegal encoding is reported ahead of misalignment.
    always_comb begin
        err_o = ERR_OK;
        if (!funct3_legal(is_store_i, funct3_i)) begin
            err_o = ERR_ILLEGAL;
        end else if ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) begin
            err_o = ERR_MISALIGN;
        end else if ((funct3_i == F3_LW) && (addr_lo_i != 2'b00)) begin
            err_o = ERR_MISALIGN;
        end else begin
            err_o = ERR_OK;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store, checks it, runs the memory access
// with an optional timeout and returns a single-cycle response beat.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_req_if.slave   req_if,
    lsu_mem_if.master  mem_if
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

    lsu_state_e            state_q,      state_d;
    logic                  is_store_q,   is_store_d;
    logic [2:0]            funct3_q,     funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  req_ready_q,  req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    lsu_err_e              resp_err_q,   resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  mem_req_q,    mem_req_d;
    logic                  mem_wr_en_q,  mem_wr_en_d;
    lsu_err_e              chk_err_s;

    lsu_access_check u_access_check (
        .is_store_i (req_if.is_store),
        .funct3_i   (req_if.funct3),
        .addr_lo_i  (req_if.addr[1:0]),
        .err_o      (chk_err_s)
    );

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        mem_req_d    = 1'b0;
        mem_wr_en_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_if.valid) begin
                    is_store_d = req_if.is_store;
                    funct3_d   = req_if.funct3;
                    addr_d     = req_if.addr;
                    wdata_d    = req_if.wdata;
                    if (chk_err_s != ERR_OK) begin
                        resp_err_d   = chk_err_s;
                        resp_rdata_d = {DATA_WIDTH{1'b0}};
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        cnt_d       = {CNT_W{1'b0}};
                        mem_req_d   = 1'b1;
                        mem_wr_en_d = req_if.is_store;
                        state_d     = ST_ACCESS;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (mem_if.ready) begin
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = is_store_q ? {DATA_WIDTH{1'b0}} : mem_if.rd_data;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    // A store abandoned here may never have reached memory.
                    resp_err_d   = ERR_TIMEOUT;
                    resp_rdata_d = {DATA_WIDTH{1'b0}};
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    if (TIMEOUT_CYCLES != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    mem_req_d   = 1'b1;
                    mem_wr_en_d = is_store_q;
                end
            end
            ST_RESP: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, request latch, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= ERR_OK;
            resp_rdata_q <= {DATA_WIDTH{1'b0}};
            mem_req_q    <= 1'b0;
            mem_wr_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_wr_en_q  <= mem_wr_en_d;
        end
    end

    assign req_if.ready      = req_ready_q;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_err   = resp_err_q;
    assign req_if.resp_rdata = resp_rdata_q;
    assign mem_if.req        = mem_req_q;
    assign mem_if.wr_en      = mem_wr_en_q;
    assign mem_if.funct3     = funct3_q;
    assign mem_if.addr       = addr_q;
    assign mem_if.wr_data    = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-organised memory model, byte-level reference shadow,
// directed RV32I cases then randomized traffic with random memory stalls.
module tb_load_store_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    lsu_req_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) rq ();
    lsu_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mm ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (rq),
        .mem_if (mm)
    );

    always #5 clk = ~clk;

    // Memory model: 64 words, little-endian lanes, extends loads per funct3.
    logic [31:0] mem_w [64] = '{default: 32'h0};
    logic [31:0] rd_w;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    always_comb begin
        rd_w = mem_w[mm.addr[7:2]];
        rd_b = 8'(rd_w >> {mm.addr[1:0], 3'b000});
        rd_h = 16'(rd_w >> {mm.addr[1], 4'b0000});
        case (mm.funct3)
            3'b000:  mm.rd_data = {{24{rd_b[7]}}, rd_b};
            3'b001:  mm.rd_data = {{16{rd_h[15]}}, rd_h};
            3'b100:  mm.rd_data = {24'h0, rd_b};
            3'b101:  mm.rd_data = {16'h0, rd_h};
            default: mm.rd_data = rd_w;
        endcase
    end

    always @(posedge clk) begin
        if (mm.req && mm.wr_en && mm.ready) begin
            case (mm.funct3)
                3'b000: mem_w[mm.addr[7:2]] <= (mem_w[mm.addr[7:2]] & ~(32'hFF << {mm.addr[1:0], 3'b000}))
                                             | ({24'h0, mm.wr_data[7:0]} << {mm.addr[1:0], 3'b000});
                3'b001: mem_w[mm.addr[7:2]] <= (mem_w[mm.addr[7:2]] & ~(32'hFFFF << {mm.addr[1], 4'b0000}))
                                             | ({16'h0, mm.wr_data[15:0]} << {mm.addr[1], 4'b0000});
                default: mem_w[mm.addr[7:2]] <= mm.wr_data;
            endcase
        end
    end

    // Reference shadow of memory contents, one byte per entry.
    logic [7:0] shadow [256] = '{default: 8'h00};

    function automatic logic [1:0] ref_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b10;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 2'b01;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [7:0]  hb;
        logic [7:0]  wb;
        b  = shadow[a[7:0]];
        hb = {a[7:1], 1'b0};
        wb = {a[7:2], 2'b00};
        h  = {shadow[hb + 8'd1], shadow[hb]};
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return {shadow[wb + 8'd3], shadow[wb + 8'd2], shadow[wb + 8'd1], shadow[wb]};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] base;
        case (f3)
            3'd0: shadow[a[7:0]] = wd[7:0];
            3'd1: begin
                base = {a[7:1], 1'b0};
                shadow[base]        = wd[7:0];
                shadow[base + 8'd1] = wd[15:8];
            end
            default: begin
                base = {a[7:2], 2'b00};
                for (int k = 0; k < 4; k++) shadow[base + 8'(k)] = wd[8*k +: 8];
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; stall = number of ACCESS cycles with mem_ready low (>=16 forces timeout).
    task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int stall);
        logic [1:0]  eerr;
        logic [31:0] erd;
        int          lat, acc, exp_lat, exp_acc;
        bit          seen, fields_ok;
        eerr = ref_err(st, f3, a);
        erd  = (eerr == 2'b00 && !st) ? ref_load(f3, a) : 32'h0;
        if (eerr != 2'b00) begin
            exp_lat = 1; exp_acc = 0;
        end else if (stall >= 16) begin
            eerr = 2'b11; erd = 32'h0; exp_lat = 17; exp_acc = 16;
        end else begin
            exp_lat = 2 + stall; exp_acc = stall + 1;
        end

        @(negedge clk);
        rq.valid = 1'b1; rq.is_store = st; rq.funct3 = f3; rq.addr = a; rq.wdata = wd;
        mm.ready = 1'b0;
        lat = 0; acc = 0; seen = 1'b0; fields_ok = 1'b1;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            rq.valid = 1'b0;
            lat++;
            if (mm.req) begin
                acc++;
                if (mm.addr !== a || mm.funct3 !== f3 || mm.wr_en !== st || (st && mm.wr_data !== wd))
                    fields_ok = 1'b0;
            end
            mm.ready = (acc > stall);
            if (rq.resp_valid) seen = 1'b1;
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        check({tag, "_err"}, 32'(rq.resp_err), 32'(eerr));
        check({tag, "_rdata"}, rq.resp_rdata, erd);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_access_cycles"}, 32'(acc), 32'(exp_acc));
        check({tag, "_mem_fields"}, 32'(fields_ok), 32'd1);
        @(posedge clk); #1;
        check({tag, "_one_beat"}, 32'(rq.resp_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(rq.ready), 32'd1);
        check({tag, "_err_hold"}, 32'(rq.resp_err), 32'(eerr));
        if (st && eerr == 2'b00) ref_store(f3, a, wd);
    endtask

    initial begin
        int hits;
        rq.valid = 1'b0; rq.is_store = 1'b0; rq.funct3 = 3'b000; rq.addr = 32'h0; rq.wdata = 32'h0;
        mm.ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(rq.ready), 32'd1);
        check("rst_resp_valid", 32'(rq.resp_valid), 32'd0);
        check("rst_resp_err", 32'(rq.resp_err), 32'd0);
        check("rst_resp_rdata", rq.resp_rdata, 32'h0);
        check("rst_mem_req", 32'(mm.req), 32'd0);
        check("rst_mem_wr_en", 32'(mm.wr_en), 32'd0);
        check("rst_mem_addr", mm.addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed RV32I cases
        do_op("sw_10",      1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        do_op("lw_10",      1'b0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_10_value", ref_load(3'b010, 32'h10), 32'hDEADBEEF);
        do_op("sb_13",      1'b1, 3'b000, 32'h13, 32'h80, 0);
        do_op("lb_13",      1'b0, 3'b000, 32'h13, 32'h0, 0);
        do_op("lbu_13",     1'b0, 3'b100, 32'h13, 32'h0, 0);
        do_op("lhu_12",     1'b0, 3'b101, 32'h12, 32'h0, 0);
        check("lhu_12_value", ref_load(3'b101, 32'h12), 32'h000080AD);
        do_op("lw_12_mis",  1'b0, 3'b010, 32'h12, 32'h0, 0);
        do_op("sh_11_mis",  1'b1, 3'b001, 32'h11, 32'hCAFE, 0);
        do_op("lw_10_after", 1'b0, 3'b010, 32'h10, 32'h0, 0);
        do_op("ld_f3_011",  1'b0, 3'b011, 32'h10, 32'h0, 0);
        do_op("st_f3_100",  1'b1, 3'b100, 32'h10, 32'h1234, 0);
        do_op("sw_stall3",  1'b1, 3'b010, 32'h24, 32'h01020304, 3);
        do_op("sw_timeout", 1'b1, 3'b010, 32'h20, 32'h55AA55AA, 1000);
        do_op("lw_20",      1'b0, 3'b010, 32'h20, 32'h0, 0);

        // Async reset in the middle of a stalled store
        @(negedge clk);
        rq.valid = 1'b1; rq.is_store = 1'b1; rq.funct3 = 3'b010; rq.addr = 32'h30; rq.wdata = 32'h11223344;
        mm.ready = 1'b0;
        @(posedge clk); #1;
        rq.valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_wr_en_before", 32'(mm.wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(mm.wr_en), 32'd0);
        check("mid_rst_mem_req", 32'(mm.req), 32'd0);
        check("mid_rst_req_ready", 32'(rq.ready), 32'd1);
        check("mid_rst_resp_valid", 32'(rq.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mm.ready = 1'b1;
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rq.resp_valid || mm.req) hits++;
        end
        check("post_rst_quiet", 32'(hits), 32'd0);
        do_op("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2) + ((!st && $urandom_range(0, 1) == 1) ? 4 : 0))
                                            : 3'($urandom_range(0, 7));
            a  = {$urandom_range(0, 255) > 200 ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 255))};
            do_op("rand", st, f3, a, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
